// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter
// Shares one AXI-style memory read channel between the i-cache (M0) and the
// d-cache (M1). Round-robin grant, a single outstanding transaction, and the
// returned beats are steered to the granted requester only.
module mem_read_arbiter #(
  parameter int ADDR_W = 26,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  // requester 0 (i-cache)
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic [LEN_W-1:0]  m0_arlen,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  // requester 1 (d-cache)
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic [LEN_W-1:0]  m1_arlen,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  // memory side
  output logic [ADDR_W-1:0] s_araddr,
  output logic [LEN_W-1:0]  s_arlen,
  output logic [3:0]        s_arid,
  output logic              s_arvalid,
  input  logic              s_arready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_rvalid,
  output logic              s_rready,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  state_t            state_r;
  logic              grant_r;
  logic              last_grant_r;
  logic [ADDR_W-1:0] araddr_r;
  logic [LEN_W-1:0]  arlen_r;
  logic [LEN_W-1:0]  beats_left_r;

  logic              req_any_s;
  logic              pick_s;
  logic              in_addr_s;
  logic              in_data_s;
  logic              sel_rready_s;
  logic              beat_hs_s;

  // Round-robin choice: on contention the requester not served last time wins
  always_comb begin
    req_any_s = m0_arvalid | m1_arvalid;
    if (m0_arvalid && m1_arvalid) begin
      pick_s = ~last_grant_r;
    end else if (m1_arvalid) begin
      pick_s = 1'b1;
    end else begin
      pick_s = 1'b0;
    end
  end

  // Steer handshakes between memory and the granted requester only
  always_comb begin
    in_addr_s    = (state_r == ST_ADDR);
    in_data_s    = (state_r == ST_DATA);
    sel_rready_s = grant_r ? m1_rready : m0_rready;
    s_arvalid    = in_addr_s;
    s_rready     = in_data_s & sel_rready_s;
    m0_arready   = in_addr_s & ~grant_r & s_arready;
    m1_arready   = in_addr_s &  grant_r & s_arready;
    m0_rvalid    = in_data_s & ~grant_r & s_rvalid;
    m1_rvalid    = in_data_s &  grant_r & s_rvalid;
    beat_hs_s    = in_data_s & s_rvalid & sel_rready_s;
  end

  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;
  assign s_araddr = araddr_r;
  assign s_arlen  = arlen_r;
  assign s_arid   = {3'b000, grant_r};
  assign busy     = (state_r != ST_IDLE);

  // Transaction sequencing: arbitrate, issue the latched address, count beats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      grant_r      <= 1'b0;
      last_grant_r <= 1'b1;
      araddr_r     <= '0;
      arlen_r      <= '0;
      beats_left_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_any_s) begin
            grant_r  <= pick_s;
            araddr_r <= pick_s ? m1_araddr : m0_araddr;
            arlen_r  <= pick_s ? m1_arlen : m0_arlen;
            state_r  <= ST_ADDR;
          end else begin
            state_r  <= ST_IDLE;
          end
        end
        ST_ADDR: begin
          if (s_arready) begin
            // a zero length is served as a single beat
            beats_left_r <= (arlen_r == '0) ? LEN_ONE : arlen_r;
            state_r      <= ST_DATA;
          end else begin
            state_r      <= ST_ADDR;
          end
        end
        ST_DATA: begin
          if (beat_hs_s) begin
            if (beats_left_r <= LEN_ONE) begin
              // last beat: saturate at zero and remember who was served
              beats_left_r <= '0;
              last_grant_r <= grant_r;
              state_r      <= ST_IDLE;
            end else begin
              beats_left_r <= beats_left_r - LEN_ONE;
            end
          end else begin
            state_r <= ST_DATA;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Testbench for mem_read_arbiter: transaction-level reference model with
// randomized requesters and a randomized memory responder.
module tb_mem_read_arbiter;

  logic        clk;
  logic        rst_n;
  logic [25:0] m0_araddr, m1_araddr, s_araddr;
  logic [7:0]  m0_arlen, m1_arlen, s_arlen;
  logic        m0_arvalid, m1_arvalid, m0_arready, m1_arready;
  logic [31:0] m0_rdata, m1_rdata, s_rdata;
  logic        m0_rvalid, m1_rvalid, m0_rready, m1_rready;
  logic [3:0]  s_arid;
  logic        s_arvalid, s_arready, s_rvalid, s_rready, busy;

  mem_read_arbiter #(.ADDR_W(26), .DATA_W(32), .LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arvalid(m0_arvalid),
    .m0_arready(m0_arready), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
    .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arvalid(m1_arvalid),
    .m1_arready(m1_arready), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
    .m1_rready(m1_rready),
    .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arid(s_arid),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_rdata(s_rdata),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // requester state
  logic        pend[2];
  logic [25:0] raddr[2];
  logic [7:0]  rlen[2];
  bit          repeat_req[2];
  int          exp_beats[2];
  // memory responder knobs
  int          ar_stall;
  int          ar_wait;
  int          gap_mode;     // 0 dense, 1 alternating, 2 random
  bit          gap_phase;
  bit          rready_rand;
  bit          stray_rvalid;
  // reference model: phase 0 idle, 1 address, 2 data
  int          mph;
  bit          m_last;
  bit          m_id;
  logic [25:0] m_addr;
  logic [7:0]  m_len;
  int          m_left;
  int          beats_fwd[2];
  int          arr_cnt[2];
  int          issued[$];

  task automatic model_clear();
    mph = 0; m_last = 1'b1; m_id = 1'b0; m_left = 0;
    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b0; repeat_req[i] = 1'b0; exp_beats[i] = 0;
      beats_fwd[i] = 0; arr_cnt[i] = 0;
    end
    issued.delete();
    ar_stall = 0; ar_wait = 0; gap_mode = 0; gap_phase = 1'b1;
    rready_rand = 1'b0; stray_rvalid = 1'b0;
  endtask

  task automatic new_req(input int i, input logic [7:0] len);
    pend[i]  = 1'b1;
    raddr[i] = 26'($urandom());
    rlen[i]  = len;
    exp_beats[i] += (len == 8'd0) ? 1 : int'(len);
  endtask

  // One clock of stimulus plus monitoring against the reference model
  task automatic cycle();
    logic [6:0] exp_ctl, obs_ctl;
    logic       pick;
    logic       sel_rdy;
    @(negedge clk);
    m0_arvalid = pend[0]; m0_araddr = raddr[0]; m0_arlen = rlen[0];
    m1_arvalid = pend[1]; m1_araddr = raddr[1]; m1_arlen = rlen[1];
    s_arready  = (mph == 1) ? (ar_wait >= ar_stall) : 1'($urandom_range(1, 0));
    if (mph == 2) begin
      if (gap_mode == 0) s_rvalid = 1'b1;
      else if (gap_mode == 1) s_rvalid = gap_phase;
      else s_rvalid = 1'($urandom_range(1, 0));
    end else begin
      s_rvalid = stray_rvalid ? 1'($urandom_range(1, 0)) : 1'b0;
    end
    s_rdata   = $urandom();
    m0_rready = rready_rand ? 1'($urandom_range(1, 0)) : 1'b1;
    m1_rready = rready_rand ? 1'($urandom_range(1, 0)) : 1'b1;
    #1;
    sel_rdy = m_id ? m1_rready : m0_rready;
    exp_ctl = {mph != 0, mph == 1,
               (mph == 1) && !m_id && s_arready, (mph == 1) && m_id && s_arready,
               (mph == 2) && !m_id && s_rvalid,  (mph == 2) && m_id && s_rvalid,
               (mph == 2) && sel_rdy};
    obs_ctl = {busy, s_arvalid, m0_arready, m1_arready, m0_rvalid, m1_rvalid, s_rready};
    n_cmp++;
    if (obs_ctl !== exp_ctl) begin
      n_bad++;
      $display("FAIL ctl @%0t: {busy,arv,ar0,ar1,rv0,rv1,rr} got %b expected %b", $time, obs_ctl, exp_ctl);
    end
    n_cmp++;
    if (m0_rdata !== s_rdata || m1_rdata !== s_rdata) begin
      n_bad++;
      $display("FAIL rdata @%0t: got %h/%h expected %h", $time, m0_rdata, m1_rdata, s_rdata);
    end
    if (mph == 1) begin
      n_cmp++;
      if (s_arid !== {3'b000, m_id} || s_araddr !== m_addr || s_arlen !== m_len) begin
        n_bad++;
        $display("FAIL ar_fields @%0t: got id %0d addr %h len %0d expected id %0d addr %h len %0d",
                 $time, s_arid, s_araddr, s_arlen, m_id, m_addr, m_len);
      end
    end
    if (m0_arready) arr_cnt[0]++;
    if (m1_arready) arr_cnt[1]++;
    // advance the model to what the coming clock edge completes
    case (mph)
      0: begin
        if (pend[0] || pend[1]) begin
          if (pend[0] && pend[1]) pick = ~m_last;
          else pick = pend[1];
          m_id = pick; m_addr = raddr[pick]; m_len = rlen[pick];
          ar_wait = 0; mph = 1;
          issued.push_back(int'(pick));
        end
      end
      1: begin
        if (s_arready) begin
          m_left = (m_len == 8'd0) ? 1 : int'(m_len);
          mph = 2; gap_phase = 1'b1;
          if (repeat_req[m_id]) begin
            raddr[m_id] = 26'($urandom()); rlen[m_id] = 8'($urandom_range(5, 0));
          end else begin
            pend[m_id] = 1'b0;
          end
        end else begin
          ar_wait++;
        end
      end
      default: begin
        if (s_rvalid && sel_rdy) begin
          beats_fwd[m_id]++;
          m_left--;
          if (m_left == 0) begin
            m_last = m_id; mph = 0;
          end
        end
        if (gap_mode == 1) gap_phase = ~gap_phase;
      end
    endcase
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    m0_arvalid = 1'b0; m1_arvalid = 1'b0; m0_rready = 1'b0; m1_rready = 1'b0;
    s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = 32'd0;
    m0_araddr = 26'd0; m1_araddr = 26'd0; m0_arlen = 8'd0; m1_arlen = 8'd0;
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_done(input string name);
    int budget;
    budget = 0;
    while ((mph != 0 || pend[0] || pend[1]) && budget < 400) begin
      cycle();
      budget++;
    end
    cycle();
    n_cmp++;
    if (budget >= 400) begin
      n_bad++;
      $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, budget);
    end
  endtask

  task automatic check_beats(input string name);
    n_cmp++;
    if (beats_fwd[0] != exp_beats[0] || beats_fwd[1] != exp_beats[1]) begin
      n_bad++;
      $display("FAIL %s_beats: got %0d/%0d expected %0d/%0d", name,
               beats_fwd[0], beats_fwd[1], exp_beats[0], exp_beats[1]);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, s_arvalid, s_rready, m0_arready, m1_arready, m0_rvalid, m1_rvalid} !== 7'd0 ||
        s_araddr !== 26'd0 || s_arlen !== 8'd0 || s_arid !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_state: busy %b arv %b addr %h len %0d id %0d, required all 0",
               busy, s_arvalid, s_araddr, s_arlen, s_arid);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    apply_reset();
    new_req(0, 8'd4);
    raddr[0] = 26'h100;
    cycle();
    cycle();
    n_cmp++;
    if (s_arvalid !== 1'b1 || s_arid !== 4'd0 || s_araddr !== 26'h100) begin
      n_bad++;
      $display("FAIL single_latency: arvalid %b id %0d addr %h, required 1 0 100", s_arvalid, s_arid, s_araddr);
    end
    wait_done("single");
    check_beats("single");
    n_cmp++;
    if (beats_fwd[1] != 0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL single_route: m1 beats %0d busy %b, required 0 0", beats_fwd[1], busy);
    end
  endtask

  task automatic test_both();
    apply_reset();
    new_req(0, 8'($urandom_range(4, 1)));
    new_req(1, 8'($urandom_range(4, 1)));
    wait_done("both");
    check_beats("both");
    n_cmp++;
    if (issued.size() != 2 || issued[0] != 0 || issued[1] != 1) begin
      n_bad++;
      $display("FAIL both_order: got %0d grants, first %0d, required 0 then 1", issued.size(), issued[0]);
    end
  endtask

  task automatic test_alternate();
    int budget;
    apply_reset();
    gap_mode = 2; rready_rand = 1'b1;
    new_req(0, 8'($urandom_range(5, 0)));
    new_req(1, 8'($urandom_range(5, 0)));
    repeat_req[0] = 1'b1; repeat_req[1] = 1'b1;
    budget = 0;
    while (issued.size() < 4 && budget < 600) begin
      cycle();
      budget++;
    end
    repeat_req[0] = 1'b0; repeat_req[1] = 1'b0;
    wait_done("alternate");
    n_cmp++;
    if (issued.size() < 4) begin
      n_bad++;
      $display("FAIL alternate_count: got %0d grants, required at least 4", issued.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (issued[k] != (k % 2)) begin
          n_bad++;
          $display("FAIL alternate_grant%0d: got %0d expected %0d", k, issued[k], k % 2);
        end
      end
    end
  endtask

  task automatic test_stall_drop();
    int who;
    apply_reset();
    ar_stall = 5; gap_mode = 1;
    who = int'($urandom_range(1, 0));
    new_req(who, 8'd4);
    cycle();
    cycle();
    pend[who] = 1'b0;   // requester withdraws while its address is pending
    wait_done("stall");
    check_beats("stall");
    n_cmp++;
    if (arr_cnt[who] != 1 || arr_cnt[1-who] != 0) begin
      n_bad++;
      $display("FAIL stall_arready: pulses %0d/%0d, required one on m%0d", arr_cnt[0], arr_cnt[1], who);
    end
  endtask

  task automatic test_len0();
    apply_reset();
    stray_rvalid = 1'b1;
    repeat (3) cycle();
    new_req(1, 8'd0);
    wait_done("len0");
    check_beats("len0");
  endtask

  task automatic test_random();
    int reqs;
    int budget;
    apply_reset();
    gap_mode = 2; rready_rand = 1'b1; stray_rvalid = 1'b1;
    reqs = 0; budget = 0;
    while (reqs < 30 && budget < 3000) begin
      ar_stall = int'($urandom_range(3, 0));
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && reqs < 30 && $urandom_range(3, 0) == 0) begin
          new_req(i, 8'($urandom_range(5, 0)));
          reqs++;
        end
      end
      cycle();
      budget++;
    end
    wait_done("random");
    check_beats("random");
  endtask

  task automatic test_reset_mid();
    int budget;
    logic [7:0] l1;
    apply_reset();
    new_req(0, 8'd4);
    budget = 0;
    while (beats_fwd[0] < 1 && budget < 50) begin
      cycle();
      budget++;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, s_arvalid, s_rready, m0_arready, m1_arready, m0_rvalid, m1_rvalid} !== 7'd0) begin
      n_bad++;
      $display("FAIL reset_mid: {busy,arv,rr,ar0,ar1,rv0,rv1} got %b, required 0",
               {busy, s_arvalid, s_rready, m0_arready, m1_arready, m0_rvalid, m1_rvalid});
    end
    model_clear();
    s_rvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    l1 = 8'($urandom_range(6, 1));
    new_req(1, l1);
    wait_done("after_reset");
    check_beats("after_reset");
    n_cmp++;
    if (issued.size() != 1 || issued[0] != 1) begin
      n_bad++;
      $display("FAIL after_reset_grant: got %0d grants, required one to m1", issued.size());
    end
  endtask

  initial begin
    rst_n = 1'b1;
    model_clear();
    test_reset();
    test_single();
    test_both();
    test_alternate();
    test_stall_drop();
    test_len0();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
